// File: rtl/deadlock_block_reporter.sv
// Watches the AXIS deadlock monitor and declares a deadlock once the block condition has held,
// with unchanged info, long enough. The frozen snapshot is delivered once over a valid/ready port.
module deadlock_block_reporter #(
  parameter int NUM_CHAN        = 3,
  parameter int INFO_W          = 3,
  parameter int STALL_THRESHOLD = 1000,
  parameter int CNT_W           = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       block,
  input  logic [NUM_CHAN*INFO_W-1:0] axis_block_info,
  input  logic                       clear,
  input  logic                       report_ready,
  output logic                       report_valid,
  output logic [NUM_CHAN*INFO_W-1:0] report_info,
  output logic [NUM_CHAN-1:0]        report_chan_mask,
  output logic [CNT_W-1:0]           stall_cycles,
  output logic [7:0]                 report_count,
  output logic                       deadlock,
  output logic [1:0]                 fsm_state
);

  // Report port: a transfer happens on every rising edge where report_valid and report_ready
  // are both high. report_valid never drops before that edge, and report_info is held while it is high.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WATCH  = 2'd1,
    REPORT = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] THRESH    = CNT_W'(STALL_THRESHOLD);
  localparam logic [CNT_W-1:0] THRESH_M1 = CNT_W'(STALL_THRESHOLD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t                       state, state_nxt;
  logic [CNT_W-1:0]             cnt, cnt_nxt, cnt_sat_inc;
  logic [NUM_CHAN*INFO_W-1:0]   snap, snap_nxt;
  logic [7:0]                   count, count_nxt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      snap  <= '0;
      count <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      snap  <= snap_nxt;
      count <= count_nxt;
    end
  end

  // Once declared, the counter keeps measuring the episode but must not wrap.
  assign cnt_sat_inc = (cnt == '1) ? cnt : cnt + CNT_ONE;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    snap_nxt  = snap;
    count_nxt = count;
    case (state)
      IDLE: begin
        if (block) begin
          state_nxt = WATCH;
          cnt_nxt   = CNT_ONE;
          snap_nxt  = axis_block_info;
        end
      end
      WATCH: begin
        if (!block) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (axis_block_info != snap) begin
          cnt_nxt  = CNT_ONE;
          snap_nxt = axis_block_info;
        end else if (cnt == THRESH_M1) begin
          state_nxt = REPORT;
          cnt_nxt   = THRESH;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      REPORT: begin
        if (block) cnt_nxt = cnt_sat_inc;
        if (report_ready) begin
          state_nxt = HOLD;
          count_nxt = (count == 8'hFF) ? count : count + 8'd1;
        end
      end
      HOLD: begin
        if (clear) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (block) begin
          cnt_nxt = cnt_sat_inc;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign report_valid = (state == REPORT);
  assign deadlock     = (state == REPORT) || (state == HOLD);
  assign report_info  = deadlock ? snap : '0;
  assign stall_cycles = cnt;
  assign report_count = count;
  assign fsm_state    = state;

  always_comb begin
    report_chan_mask = '0;
    for (int k = 0; k < NUM_CHAN; k++) begin
      report_chan_mask[k] = |report_info[k*INFO_W +: INFO_W];
    end
  end

endmodule

// File: tb/tb_deadlock_block_reporter.sv
// Bench for deadlock_block_reporter: directed episodes plus random traffic against a run-length
// reference model; delivered reports are checked by a monitor that pops an expected queue.
module tb_deadlock_block_reporter;

  localparam int TH = 4;
  localparam int NC = 3;
  localparam int IW = 3;
  localparam int CW = 8;
  localparam int DW = NC * IW;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          block = 1'b0;
  logic [DW-1:0] axis_block_info = '0;
  logic          clear = 1'b0;
  logic          report_ready = 1'b0;
  logic          report_valid;
  logic [DW-1:0] report_info;
  logic [NC-1:0] report_chan_mask;
  logic [CW-1:0] stall_cycles;
  logic [7:0]    report_count;
  logic          deadlock;
  logic [1:0]    fsm_state;

  deadlock_block_reporter #(
    .NUM_CHAN(NC), .INFO_W(IW), .STALL_THRESHOLD(TH), .CNT_W(CW)
  ) dut (
    .clock(clock), .reset(reset), .block(block), .axis_block_info(axis_block_info),
    .clear(clear), .report_ready(report_ready), .report_valid(report_valid),
    .report_info(report_info), .report_chan_mask(report_chan_mask),
    .stall_cycles(stall_cycles), .report_count(report_count), .deadlock(deadlock),
    .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: length of the current stable blocked run, declared/delivered flags
  bit            m_decl = 0;
  bit            m_pend = 0;
  int            m_run = 0;
  int            m_stall = 0;
  int            m_count = 0;
  logic [DW-1:0] m_last = '0;
  logic [DW-1:0] exp_q[$];

  function automatic logic [NC-1:0] mask_of(input logic [DW-1:0] v);
    logic [NC-1:0] m;
    for (int k = 0; k < NC; k++) m[k] = (v[k*IW +: IW] != '0);
    return m;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 30) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic b, input logic [DW-1:0] i, input logic c, input logic r);
    if (!m_decl) begin
      if (!b) m_run = 0;
      else if (m_run == 0 || i != m_last) begin
        m_run  = 1;
        m_last = i;
      end else begin
        m_run++;
        if (m_run == TH) begin
          m_decl = 1;
          m_pend = 1;
          exp_q.push_back(m_last);
        end
      end
      m_stall = m_run;
    end else if (m_pend) begin
      if (r) begin
        m_pend = 0;
        if (m_count < 255) m_count++;
      end
      if (b && m_stall < 255) m_stall++;
    end else begin
      if (c) begin
        m_decl  = 0;
        m_run   = 0;
        m_stall = 0;
      end else if (b && m_stall < 255) m_stall++;
    end
  endtask

  // driver: apply inputs, let one edge sample them, then compare against the model
  task automatic step(input logic b, input logic [DW-1:0] i, input logic c, input logic r);
    block = b; axis_block_info = i; clear = c; report_ready = r;
    @(posedge clock);
    #1;
    model_edge(b, i, c, r);
    check("report_valid", 32'(report_valid), 32'(m_decl && m_pend));
    check("deadlock", 32'(deadlock), 32'(m_decl));
    check("stall_cycles", 32'(stall_cycles), 32'(m_stall));
    check("report_count", 32'(report_count), 32'(m_count));
    check("report_info", 32'(report_info), m_decl ? 32'(m_last) : 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(report_valid), 32'd0);
    check({tag, "_info"}, 32'(report_info), 32'd0);
    check({tag, "_mask"}, 32'(report_chan_mask), 32'd0);
    check({tag, "_stall"}, 32'(stall_cycles), 32'd0);
    check({tag, "_count"}, 32'(report_count), 32'd0);
    check({tag, "_deadlock"}, 32'(deadlock), 32'd0);
    check({tag, "_state"}, 32'(fsm_state), 32'd0);
  endtask

  // asynchronous reset pulse between edges, then release and restart the model
  task automatic async_reset(input string tag);
    reset = 1'b0;
    #2;
    check_all_zero(tag);
    #1;
    reset = 1'b1;
    m_decl = 0; m_pend = 0; m_run = 0; m_stall = 0; m_count = 0;
    exp_q.delete();
  endtask

  // scoreboard monitor: every completed transfer must match the oldest declared snapshot
  initial begin
    logic [DW-1:0] e;
    forever begin
      @(negedge clock);
      if (reset && report_valid && report_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL report_unexpected: got info %0h expected no report", report_info);
        end else begin
          e = exp_q.pop_front();
          check("sb_info", 32'(report_info), 32'(e));
          check("sb_mask", 32'(report_chan_mask), 32'(mask_of(e)));
        end
      end
    end
  end

  initial begin
    logic [DW-1:0] ri;
    logic          rb, rc, rr;
    ri = '0;
    #2;
    check_all_zero("reset");
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;

    // stable episode: report exactly TH edges after first sample
    for (int k = 0; k < TH; k++) step(1, 9'h006, 0, 0);
    check("t1_valid", 32'(report_valid), 32'd1);
    check("t1_info", 32'(report_info), 32'h006);
    check("t1_mask", 32'(report_chan_mask), 32'b001);
    check("t1_stall", 32'(stall_cycles), 32'd4);
    // backpressure with a clear that must be ignored
    for (int k = 0; k < 5; k++) step(1, 9'h006, k == 2, 0);
    check("t4_valid_held", 32'(report_valid), 32'd1);
    check("t4_info_held", 32'(report_info), 32'h006);
    step(1, 9'h006, 0, 1);
    check("t4_valid_drop", 32'(report_valid), 32'd0);
    check("t4_deadlock", 32'(deadlock), 32'd1);
    check("t4_count", 32'(report_count), 32'd1);
    step(0, 9'h006, 1, 0);
    check("t5_clear", 32'(deadlock), 32'd0);

    // short episode: no report
    for (int k = 0; k < 3; k++) step(1, 9'h011, 0, 0);
    step(0, 9'h011, 0, 0);
    check("t2_stall", 32'(stall_cycles), 32'd0);
    check("t2_state", 32'(fsm_state), 32'd0);

    // info change restarts the count
    step(1, 9'h006, 0, 0);
    step(1, 9'h006, 0, 0);
    for (int k = 0; k < TH; k++) step(1, 9'h02E, 0, 0);
    check("t3_info", 32'(report_info), 32'h02E);
    check("t3_mask", 32'(report_chan_mask), 32'b011);
    step(1, 9'h02E, 0, 1);
    check("t5_count", 32'(report_count), 32'd2);
    step(1, 9'h02E, 1, 0);

    // block falls and info changes together: back to idle
    step(0, 9'h000, 0, 0);
    step(1, 9'h100, 0, 0);
    step(0, 9'h1C0, 0, 0);
    check("simul_idle_stall", 32'(stall_cycles), 32'd0);
    // info change on the threshold cycle: restart, no report
    for (int k = 0; k < TH - 1; k++) step(1, 9'h040, 0, 0);
    step(1, 9'h041, 0, 0);
    check("thresh_change_valid", 32'(report_valid), 32'd0);
    check("thresh_change_stall", 32'(stall_cycles), 32'd1);
    step(0, 9'h0, 0, 0);

    // asynchronous reset mid-WATCH and mid-REPORT
    step(1, 9'h007, 0, 0);
    step(1, 9'h007, 0, 0);
    async_reset("rst_watch");
    for (int k = 0; k < TH; k++) step(1, 9'h1FF, 0, 0);
    async_reset("rst_report");
    for (int k = 0; k < TH; k++) step(1, 9'h038, 0, 0);
    check("t6_fresh_valid", 32'(report_valid), 32'd1);
    step(1, 9'h038, 0, 1);
    step(0, 9'h038, 1, 0);

    // stall counter saturation and freeze after block drops
    for (int k = 0; k < 300; k++) step(1, 9'h0A5, 0, 0);
    check("sat_stall", 32'(stall_cycles), 32'd255);
    step(0, 9'h0A5, 0, 0);
    check("sat_freeze", 32'(stall_cycles), 32'd255);
    check("sticky_deadlock", 32'(deadlock), 32'd1);
    step(0, 9'h0A5, 0, 1);
    step(0, 9'h0A5, 1, 0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      rb = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) ri = DW'($urandom_range(0, 511));
      rr = ($urandom_range(0, 1) == 1);
      rc = ($urandom_range(0, 3) == 0);
      step(rb, ri, rc, rr);
    end
    step(0, ri, 0, 1);
    step(0, ri, 1, 0);

    // report_count saturation
    for (int n = 0; n < 260; n++) begin
      ri = DW'($urandom_range(1, 511));
      for (int k = 0; k < TH + 1; k++) step(1, ri, 0, 1);
      step(0, ri, 1, 1);
    end
    check("count_sat", 32'(report_count), 32'd255);

    for (int k = 0; k < 4; k++) step(0, ri, 0, 1);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
